// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl
// Memory-mapped I/O controller sitting between the CPU MEM stage and the UART.
// Loads/stores to the 0x8xxx_xxxx region (offset Address[5:2]) reach a small
// register map: TX/RX status, a one-entry TX holding register, an RX FIFO,
// free-running cycle and retired-instruction counters, and a sticky TX overrun.
//
// Ports:
//   Clock, reset_n          system clock (rising edge), async active-low reset
//   Address, WriteData      MEM-stage address and store data
//   REUART, WEUART          load / store strobes for the I/O region
//   InstrRetire             one pulse per retired instruction
//   ReadData                registered load result (one-cycle latency)
//   DataIn, DataInValid     byte to the UART transmitter and its valid
//   DataInReady             transmitter accepts the byte
//   DataOut, DataOutValid   byte from the UART receiver and its valid
//   DataOutReady            RX FIFO has room
module uart_mmio_ctrl #(
  parameter int RX_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        reset_n,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        REUART,
  input  logic        WEUART,
  input  logic        InstrRetire,
  output logic [31:0] ReadData,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {TX_EMPTY, TX_FULL} txState_e;

  logic [7:0]    rxMem_q [RX_DEPTH];
  logic [PW-1:0] rxHead_q, rxTail_q;
  logic [CW-1:0] rxCount_q, rxCount_d;
  txState_e      txState_q, txState_d;
  logic [7:0]    txByte_q, txByte_d;
  logic          txOverrun_q, txOverrun_d;
  logic [31:0]   cycleCnt_q, cycleCnt_d;
  logic [31:0]   instrCnt_q, instrCnt_d;
  logic [31:0]   readData_q, readData_d;

  logic          inRegion, rdAcc, wrAcc;
  logic [3:0]    offset;
  logic          rxFull, rxEmpty, rxPush, rxPop;
  logic          txWrite, txHandshake, overrunSet, cntClear, overrunRead;
  logic [31:0]   rdValue;
  logic          unusedBits;

  assign inRegion = (Address[31:28] == 4'b1000);
  assign offset   = Address[5:2];
  assign rdAcc    = REUART && inRegion;
  assign wrAcc    = WEUART && inRegion;

  assign unusedBits = ^{Address[27:6], Address[1:0], WriteData[31:8]};

  // Full/empty come from registered occupancy only, so DataOutReady has no
  // combinational dependence on DataOutValid.
  assign rxFull       = (rxCount_q == CW'(RX_DEPTH));
  assign rxEmpty      = (rxCount_q == '0);
  assign rxPush       = DataOutValid && !rxFull;
  assign rxPop        = rdAcc && (offset == 4'h3) && !rxEmpty;
  assign DataOutReady = !rxFull;

  assign txWrite     = wrAcc && (offset == 4'h2);
  assign txHandshake = (txState_q == TX_FULL) && DataInReady;
  assign cntClear    = wrAcc && (offset == 4'h6);
  assign overrunRead = rdAcc && (offset == 4'h7);

  assign DataIn      = txByte_q;
  assign DataInValid = (txState_q == TX_FULL);
  assign ReadData    = readData_q;

  always_comb begin
    rxCount_d = rxCount_q;
    case ({rxPush, rxPop})
      2'b10:   rxCount_d = rxCount_q + CW'(1);
      2'b01:   rxCount_d = rxCount_q - CW'(1);
      default: rxCount_d = rxCount_q;
    endcase
  end

  // A write landing on a full register is only accepted when the pending
  // byte leaves in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    txState_d  = txState_q;
    txByte_d   = txByte_q;
    overrunSet = 1'b0;
    if (txWrite) begin
      if ((txState_q == TX_EMPTY) || txHandshake) begin
        txState_d = TX_FULL;
        txByte_d  = WriteData[7:0];
      end else begin
        overrunSet = 1'b1;
      end
    end else if (txHandshake) begin
      txState_d = TX_EMPTY;
    end
  end

  // A new overrun wins over the clear-on-read in the same cycle.
  assign txOverrun_d = (txOverrun_q && !overrunRead) || overrunSet;

  always_comb begin
    cycleCnt_d = cntClear ? 32'd0 : cycleCnt_q + 32'd1;
    instrCnt_d = cntClear ? 32'd0 : instrCnt_q + {31'd0, InstrRetire};
  end

  always_comb begin
    rdValue = 32'd0;
    if (rdAcc) begin
      case (offset)
        4'h0:    rdValue = {31'd0, txState_q == TX_EMPTY};
        4'h1:    rdValue = {31'd0, !rxEmpty};
        4'h3:    rdValue = rxEmpty ? 32'd0 : {24'd0, rxMem_q[rxHead_q]};
        4'h4:    rdValue = cycleCnt_q;
        4'h5:    rdValue = instrCnt_q;
        4'h7:    rdValue = {31'd0, txOverrun_q};
        default: rdValue = 32'd0;
      endcase
    end
    readData_d = REUART ? rdValue : readData_q;
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RX_DEPTH; i++) rxMem_q[i] <= 8'd0;
      rxHead_q    <= '0;
      rxTail_q    <= '0;
      rxCount_q   <= '0;
      txState_q   <= TX_EMPTY;
      txByte_q    <= 8'd0;
      txOverrun_q <= 1'b0;
      cycleCnt_q  <= 32'd0;
      instrCnt_q  <= 32'd0;
      readData_q  <= 32'd0;
    end else begin
      if (rxPush) begin
        rxMem_q[rxTail_q] <= DataOut;
        rxTail_q          <= rxTail_q + PW'(1);
      end
      if (rxPop) rxHead_q <= rxHead_q + PW'(1);
      rxCount_q   <= rxCount_d;
      txState_q   <= txState_d;
      txByte_q    <= txByte_d;
      txOverrun_q <= txOverrun_d;
      cycleCnt_q  <= cycleCnt_d;
      instrCnt_q  <= instrCnt_d;
      readData_q  <= readData_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl
// Self-checking bench for uart_mmio_ctrl. A behavioural model (byte queue for
// the RX FIFO, plain flags/integers for TX, overrun and counters) is advanced
// on every rising edge; a compare process checks all DUT outputs against it on
// every falling edge. Directed scenarios add literal expectations, followed by
// a randomized phase that includes an asynchronous reset mid-traffic.
module tb_uart_mmio_ctrl;

  localparam int RX_DEPTH = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        Clock = 1'b0;
  logic        reset_n;
  logic [31:0] Address, WriteData;
  logic        REUART, WEUART, InstrRetire;
  logic [31:0] ReadData;
  logic [7:0]  DataIn;
  logic        DataInValid, DataInReady;
  logic [7:0]  DataOut;
  logic        DataOutValid, DataOutReady;

  int errors = 0;
  int checks = 0;
  bit compareOn = 1'b0;

  // Behavioural model state
  logic [7:0]  mQ[$];
  logic        mTxFull = 1'b0;
  logic [7:0]  mTxByte = 8'd0;
  logic        mOvr = 1'b0;
  logic [31:0] mCyc = 32'd0;
  logic [31:0] mInst = 32'd0;
  logic [31:0] mRd = 32'd0;

  uart_mmio_ctrl #(.RX_DEPTH(RX_DEPTH)) dut (
    .Clock(Clock), .reset_n(reset_n), .Address(Address), .WriteData(WriteData),
    .REUART(REUART), .WEUART(WEUART), .InstrRetire(InstrRetire),
    .ReadData(ReadData), .DataIn(DataIn), .DataInValid(DataInValid),
    .DataInReady(DataInReady), .DataOut(DataOut), .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's access, clock it, and return #1 after the edge.
  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd);
    REUART    = re;
    WEUART    = we;
    Address   = addr;
    WriteData = wd;
    @(posedge Clock);
    #1;
    REUART = 1'b0;
    WEUART = 1'b0;
  endtask

  // Model: one transaction-level update per edge, using pre-edge state.
  initial begin : model
    logic inReg, ready, ovrSet, hs, wrTx;
    logic [3:0] off;
    logic [31:0] val;
    forever begin
      @(posedge Clock or negedge reset_n);
      if (!reset_n) begin
        mQ.delete();
        mTxFull = 1'b0; mTxByte = 8'd0; mOvr = 1'b0;
        mCyc = 32'd0; mInst = 32'd0; mRd = 32'd0;
      end else begin
        inReg  = (Address[31:28] == 4'b1000);
        off    = Address[5:2];
        ready  = (mQ.size() < RX_DEPTH);
        val    = 32'd0;
        if (REUART && inReg) begin
          case (off)
            4'h0: val = mTxFull ? 32'd0 : 32'd1;
            4'h1: val = (mQ.size() != 0) ? 32'd1 : 32'd0;
            4'h3: val = (mQ.size() != 0) ? {24'd0, mQ[0]} : 32'd0;
            4'h4: val = mCyc;
            4'h5: val = mInst;
            4'h7: val = {31'd0, mOvr};
            default: val = 32'd0;
          endcase
        end
        if (REUART) mRd = val;
        if (REUART && inReg && off == 4'h3 && mQ.size() != 0) void'(mQ.pop_front());
        if (DataOutValid && ready) mQ.push_back(DataOut);
        hs     = mTxFull && DataInReady;
        wrTx   = WEUART && inReg && off == 4'h2;
        ovrSet = 1'b0;
        if (wrTx && (!mTxFull || hs)) begin
          mTxFull = 1'b1;
          mTxByte = WriteData[7:0];
        end else if (wrTx) begin
          ovrSet = 1'b1;
        end else if (hs) begin
          mTxFull = 1'b0;
        end
        mOvr = (mOvr && !(REUART && inReg && off == 4'h7)) || ovrSet;
        if (WEUART && inReg && off == 4'h6) begin
          mCyc = 32'd0;
          mInst = 32'd0;
        end else begin
          mCyc = mCyc + 32'd1;
          mInst = mInst + {31'd0, InstrRetire};
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (compareOn) begin
      checkOutput("DataOutReady", {31'd0, DataOutReady}, {31'd0, mQ.size() < RX_DEPTH});
      checkOutput("DataInValid", {31'd0, DataInValid}, {31'd0, mTxFull});
      checkOutput("DataIn", {24'd0, DataIn}, {24'd0, mTxByte});
      checkOutput("ReadData", ReadData, mRd);
    end
  end

  initial begin
    reset_n = 1'b1;
    Address = 32'd0; WriteData = 32'd0; REUART = 1'b0; WEUART = 1'b0;
    InstrRetire = 1'b0; DataInReady = 1'b0; DataOut = 8'd0; DataOutValid = 1'b0;
    #2 reset_n = 1'b0;
    compareOn = 1'b1;
    repeat (3) @(posedge Clock);
    checkOutput("rst_DataOutReady", {31'd0, DataOutReady}, 32'd1);
    checkOutput("rst_DataInValid", {31'd0, DataInValid}, 32'd0);
    checkOutput("rst_ReadData", ReadData, 32'd0);
    #1 reset_n = 1'b1;

    // Status and cycle count right after reset release
    applyStimulus(1, 0, BASE + 32'h00, 0);
    checkOutput("rd_tx_empty", ReadData, 32'd1);
    applyStimulus(1, 0, BASE + 32'h04, 0);
    checkOutput("rd_rx_nonempty0", ReadData, 32'd0);
    applyStimulus(1, 0, BASE + 32'h10, 0);
    checkOutput("rd_cycle", ReadData, 32'd2);

    // Two received bytes, popped in order, then empty pop
    DataOutValid = 1'b1; DataOut = 8'h41;
    applyStimulus(0, 0, 0, 0);
    DataOut = 8'h42;
    applyStimulus(0, 0, 0, 0);
    DataOutValid = 1'b0;
    applyStimulus(1, 0, BASE + 32'h04, 0);
    checkOutput("rd_rx_nonempty1", ReadData, 32'd1);
    applyStimulus(1, 0, BASE + 32'h0C, 0);
    checkOutput("pop_41", ReadData, 32'h41);
    applyStimulus(1, 0, BASE + 32'h0C, 0);
    checkOutput("pop_42", ReadData, 32'h42);
    applyStimulus(1, 0, BASE + 32'h0C, 0);
    checkOutput("pop_empty", ReadData, 32'd0);
    applyStimulus(1, 0, BASE + 32'h04, 0);
    checkOutput("rd_rx_nonempty2", ReadData, 32'd0);

    // Fill the FIFO, hold a fifth byte, pop one, then the fifth gets in
    DataOutValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DataOut = 8'h10 + 8'(i);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("full_ready", {31'd0, DataOutReady}, 32'd0);
    DataOut = 8'hA5;
    applyStimulus(0, 0, 0, 0);
    checkOutput("held_ready", {31'd0, DataOutReady}, 32'd0);
    applyStimulus(1, 0, BASE + 32'h0C, 0);
    checkOutput("pop_10", ReadData, 32'h10);
    checkOutput("ready_after_pop", {31'd0, DataOutReady}, 32'd1);
    applyStimulus(0, 0, 0, 0);
    DataOutValid = 1'b0;
    checkOutput("refull_ready", {31'd0, DataOutReady}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, BASE + 32'h0C, 0);
    checkOutput("pop_A5", ReadData, 32'hA5);

    // TX overrun and handshake
    DataInReady = 1'b0;
    applyStimulus(0, 1, BASE + 32'h08, 32'h55);
    applyStimulus(0, 1, BASE + 32'h08, 32'h66);
    checkOutput("tx_kept_55", {24'd0, DataIn}, 32'h55);
    applyStimulus(1, 0, BASE + 32'h1C, 0);
    checkOutput("overrun_1", ReadData, 32'd1);
    applyStimulus(1, 0, BASE + 32'h1C, 0);
    checkOutput("overrun_cleared", ReadData, 32'd0);
    DataInReady = 1'b1;
    applyStimulus(0, 0, 0, 0);
    DataInReady = 1'b0;
    checkOutput("tx_drained", {31'd0, DataInValid}, 32'd0);

    // Write in the same cycle the pending byte handshakes
    applyStimulus(0, 1, BASE + 32'h08, 32'h33);
    DataInReady = 1'b1;
    applyStimulus(0, 1, BASE + 32'h08, 32'h77);
    DataInReady = 1'b0;
    checkOutput("tx_77", {24'd0, DataIn}, 32'h77);
    checkOutput("tx_77_valid", {31'd0, DataInValid}, 32'd1);
    applyStimulus(1, 0, BASE + 32'h1C, 0);
    checkOutput("no_overrun", ReadData, 32'd0);
    DataInReady = 1'b1;
    applyStimulus(0, 0, 0, 0);
    DataInReady = 1'b0;

    // Instruction counter and clear
    InstrRetire = 1'b1;
    repeat (10) applyStimulus(0, 0, 0, 0);
    InstrRetire = 1'b0;
    applyStimulus(1, 0, BASE + 32'h14, 0);
    checkOutput("instr_10", ReadData, 32'd10);
    applyStimulus(0, 1, BASE + 32'h18, 0);
    applyStimulus(1, 0, BASE + 32'h14, 0);
    checkOutput("instr_cleared", ReadData, 32'd0);
    InstrRetire = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 0);
    InstrRetire = 1'b0;
    applyStimulus(1, 0, BASE + 32'h14, 0);
    checkOutput("instr_3", ReadData, 32'd3);
    applyStimulus(1, 0, 32'h0000_0014, 0);
    checkOutput("out_of_region", ReadData, 32'd0);
    applyStimulus(1, 0, BASE + 32'h20, 0);
    checkOutput("unmapped", ReadData, 32'd0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] addr;
      if (n == 1500) begin
        @(posedge Clock);
        #3 reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #1 reset_n = 1'b1;
      end
      r = $urandom_range(0, 11);
      if (r < 10) addr = BASE | (32'(r) << 2) | ($urandom & 32'h0FFF_FFC3);
      else        addr = $urandom & 32'h7FFF_FFFF;
      InstrRetire  = 1'($urandom_range(0, 1));
      DataOutValid = ($urandom_range(0, 2) != 0);
      DataOut      = 8'($urandom);
      DataInReady  = ($urandom_range(0, 2) == 0);
      applyStimulus(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3), addr, $urandom);
    end

    @(negedge Clock);
    compareOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
